// File: rtl/core_pkg.sv
// Shared types for the hazard / sequencing controller.
//   fwd_sel_e  : operand forwarding source select
//   hz_state_e : sequencing FSM state
//   REG_X0     : index of the hard-wired zero register
package core_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_EX  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    ERROR    = 2'b10
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side (drives stage info, receives controls)
//   slave  : hazard controller side
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_id;
  logic [4:0]       rd_ex;
  logic             rd_wren_ex;
  logic             is_load_ex;
  logic [4:0]       rd_mem;
  logic             rd_wren_mem;
  logic             is_load_mem;
  logic [4:0]       rd_wb;
  logic             rd_wren_wb;
  logic             br_taken_ex;
  logic             mem_req;
  logic             mem_ready;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             stall_if;
  logic             bubble_ex;
  logic             flush_id;
  logic             freeze;
  logic             mem_err;
  logic [1:0]       state;
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;

  modport master (
    output instr_id, rd_ex, rd_wren_ex, is_load_ex, rd_mem, rd_wren_mem,
           is_load_mem, rd_wb, rd_wren_wb, br_taken_ex, mem_req, mem_ready,
    input  forward_a, forward_b, stall_if, bubble_ex, flush_id, freeze,
           mem_err, state, perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  instr_id, rd_ex, rd_wren_ex, is_load_ex, rd_mem, rd_wren_mem,
           is_load_mem, rd_wb, rd_wren_wb, br_taken_ex, mem_req, mem_ready,
    output forward_a, forward_b, stall_if, bubble_ex, flush_id, freeze,
           mem_err, state, perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/fwd_sel.sv
// Per-operand forwarding priority (EX > MEM > WB > regfile).
//   rs            : source register index from ID
//   rd_*/wren/ld  : destination info of the younger-to-older stages
//   sel           : chosen operand source
// A load in EX or MEM has no data yet, so it is never a forwarding source;
// the load-use stall covers that case.
module fwd_sel
  import core_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_ex,
  input  logic       rd_wren_ex,
  input  logic       is_load_ex,
  input  logic [4:0] rd_mem,
  input  logic       rd_wren_mem,
  input  logic       is_load_mem,
  input  logic [4:0] rd_wb,
  input  logic       rd_wren_wb,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_RF;
    if (rs != REG_X0) begin
      if (rd_wren_ex && (rd_ex == rs) && !is_load_ex)
        sel = FWD_EX;
      else if (rd_wren_mem && (rd_mem == rs) && !is_load_mem)
        sel = FWD_MEM;
      else if (rd_wren_wb && (rd_wb == rs))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller for the 5-stage RV32I core.
//   i_clk   : core clock
//   i_reset : asynchronous active-low reset
//   hz      : pipeline bundle (stage info in; forwarding selects, stall /
//             bubble / flush / freeze controls, error and perf counters out)
// Hazard priority: memory wait > taken-branch flush > load-use stall.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [4:0] rs1, rs2;
  fwd_sel_e   fwd_a, fwd_b;
  logic       lu;
  logic       unused_instr;

  assign rs1 = hz.instr_id[19:15];
  assign rs2 = hz.instr_id[24:20];
  assign unused_instr = ^{hz.instr_id[31:25], hz.instr_id[14:0]};

  fwd_sel u_fwd_a (
    .rs(rs1), .rd_ex(hz.rd_ex), .rd_wren_ex(hz.rd_wren_ex), .is_load_ex(hz.is_load_ex),
    .rd_mem(hz.rd_mem), .rd_wren_mem(hz.rd_wren_mem), .is_load_mem(hz.is_load_mem),
    .rd_wb(hz.rd_wb), .rd_wren_wb(hz.rd_wren_wb), .sel(fwd_a)
  );

  fwd_sel u_fwd_b (
    .rs(rs2), .rd_ex(hz.rd_ex), .rd_wren_ex(hz.rd_wren_ex), .is_load_ex(hz.is_load_ex),
    .rd_mem(hz.rd_mem), .rd_wren_mem(hz.rd_wren_mem), .is_load_mem(hz.is_load_mem),
    .rd_wb(hz.rd_wb), .rd_wren_wb(hz.rd_wren_wb), .sel(fwd_b)
  );

  // A load one or two stages ahead of its consumer cannot forward yet.
  assign lu = (hz.is_load_ex && hz.rd_wren_ex && (hz.rd_ex != REG_X0) &&
               ((hz.rd_ex == rs1) || (hz.rd_ex == rs2))) ||
              (hz.is_load_mem && hz.rd_wren_mem && (hz.rd_mem != REG_X0) &&
               ((hz.rd_mem == rs1) || (hz.rd_mem == rs2)));

  hz_state_e        state_q, state_d;
  logic [15:0]      wait_q, wait_d;
  logic             br_pend_q, br_pend_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_c, bubble_c, flush_c, freeze_c;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    br_pend_d = br_pend_q;
    mem_err_d = mem_err_q;
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    flush_c   = 1'b0;
    freeze_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          freeze_c  = 1'b1;
          state_d   = MEM_WAIT;
          wait_d    = 16'd1;
          br_pend_d = hz.br_taken_ex;
        end else if (hz.br_taken_ex) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (lu) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        br_pend_d = br_pend_q | hz.br_taken_ex;
        if (hz.mem_ready) begin
          // Release cycle: a branch seen during the wait flushes now.
          state_d   = RUN;
          wait_d    = 16'd0;
          br_pend_d = 1'b0;
          if (br_pend_q || hz.br_taken_ex) begin
            flush_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (lu) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end
        end else begin
          freeze_c = 1'b1;
          if (wait_q == TIMEOUT_W) begin
            state_d   = ERROR;
            mem_err_d = 1'b1;
          end else begin
            wait_d = wait_q + 16'd1;
          end
        end
      end
      ERROR: begin
        freeze_c = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    stall_cnt_d = stall_cnt_q;
    if ((stall_c || freeze_c) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush_c && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= RUN;
      wait_q      <= 16'd0;
      br_pend_q   <= 1'b0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      br_pend_q   <= br_pend_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // While reset is held the pipeline sees NOPs injected and nothing else.
  assign hz.forward_a      = i_reset ? fwd_a : FWD_RF;
  assign hz.forward_b      = i_reset ? fwd_b : FWD_RF;
  assign hz.stall_if       = i_reset & stall_c;
  assign hz.bubble_ex      = ~i_reset | bubble_c;
  assign hz.flush_id       = ~i_reset | flush_c;
  assign hz.freeze         = i_reset & freeze_c;
  assign hz.mem_err        = mem_err_q;
  assign hz.state          = state_q;
  assign hz.perf_stall_cnt = stall_cnt_q;
  assign hz.perf_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic i_clk;
  logic i_reset;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz();

  hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .hz     (hz.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_vec  = 0;
  int n_miss = 0;

  // reference model state: 0 RUN, 1 waiting on memory, 2 timed out
  int m_state, m_wait, m_pend, m_err, m_stall, m_flush;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_instr(input int rs1, input int rs2);
    logic [4:0] a, b;
    a = 5'(rs1);
    b = 5'(rs2);
    return {7'd0, b, a, 3'd0, 5'd1, 7'h33};
  endfunction

  task automatic idle();
    hz.instr_id = mk_instr(0, 0);
    hz.rd_ex = 0;  hz.rd_wren_ex = 0;  hz.is_load_ex = 0;
    hz.rd_mem = 0; hz.rd_wren_mem = 0; hz.is_load_mem = 0;
    hz.rd_wb = 0;  hz.rd_wren_wb = 0;
    hz.br_taken_ex = 0; hz.mem_req = 0; hz.mem_ready = 0;
  endtask

  function automatic int ref_fwd(input int rs);
    if (rs == 0) return 0;
    if (hz.rd_wren_ex && int'(hz.rd_ex) == rs && !hz.is_load_ex) return 3;
    if (hz.rd_wren_mem && int'(hz.rd_mem) == rs && !hz.is_load_mem) return 2;
    if (hz.rd_wren_wb && int'(hz.rd_wb) == rs) return 1;
    return 0;
  endfunction

  function automatic bit ref_lu();
    int r1, r2;
    bit ex_hit, mem_hit;
    r1 = int'(hz.instr_id[19:15]);
    r2 = int'(hz.instr_id[24:20]);
    ex_hit  = hz.is_load_ex && hz.rd_wren_ex && hz.rd_ex != 0 &&
              (int'(hz.rd_ex) == r1 || int'(hz.rd_ex) == r2);
    mem_hit = hz.is_load_mem && hz.rd_wren_mem && hz.rd_mem != 0 &&
              (int'(hz.rd_mem) == r1 || int'(hz.rd_mem) == r2);
    return ex_hit || mem_hit;
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_pend = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // One clock: check combinational and registered outputs at the falling
  // edge, then advance the model across the rising edge.
  task automatic step();
    int st, bub, fl, fz;
    int n_state, n_wait, n_pend, n_err;
    bit lu;
    @(negedge i_clk);
    lu = ref_lu();
    st = 0; bub = 0; fl = 0; fz = 0;
    n_state = m_state; n_wait = m_wait; n_pend = m_pend; n_err = m_err;
    if (m_state == 0) begin
      if (hz.mem_req && !hz.mem_ready) begin
        fz = 1; n_state = 1; n_wait = 1; n_pend = hz.br_taken_ex;
      end else if (hz.br_taken_ex) begin
        fl = 1; bub = 1;
      end else if (lu) begin
        st = 1; bub = 1;
      end
    end else if (m_state == 1) begin
      if (hz.mem_ready) begin
        n_state = 0; n_pend = 0; n_wait = 0;
        if (m_pend != 0 || hz.br_taken_ex) begin
          fl = 1; bub = 1;
        end else if (lu) begin
          st = 1; bub = 1;
        end
      end else begin
        fz = 1;
        n_pend = m_pend | int'(hz.br_taken_ex);
        if (m_wait == TIMEOUT) begin
          n_state = 2; n_err = 1;
        end else begin
          n_wait = m_wait + 1;
        end
      end
    end else begin
      fz = 1;
    end
    chk("forward_a", 32'(hz.forward_a), 32'(ref_fwd(int'(hz.instr_id[19:15]))));
    chk("forward_b", 32'(hz.forward_b), 32'(ref_fwd(int'(hz.instr_id[24:20]))));
    chk("stall_if",  32'(hz.stall_if),  32'(st));
    chk("bubble_ex", 32'(hz.bubble_ex), 32'(bub));
    chk("flush_id",  32'(hz.flush_id),  32'(fl));
    chk("freeze",    32'(hz.freeze),    32'(fz));
    chk("mem_err",   32'(hz.mem_err),   32'(m_err));
    chk("state",     32'(hz.state),     32'(m_state));
    chk("perf_stall", 32'(hz.perf_stall_cnt), 32'(m_stall));
    chk("perf_flush", 32'(hz.perf_flush_cnt), 32'(m_flush));
    @(posedge i_clk);
    m_state = n_state; m_wait = n_wait; m_pend = n_pend; m_err = n_err;
    if ((st != 0 || fz != 0) && m_stall < CNT_MAX) m_stall++;
    if (fl != 0 && m_flush < CNT_MAX) m_flush++;
    #1;
  endtask

  // Asynchronous reset asserted between clock edges; effects must be visible
  // before any further clock edge.
  task automatic do_reset();
    i_reset = 1'b0;
    #2;
    chk("rst_state",     32'(hz.state), 0);
    chk("rst_mem_err",   32'(hz.mem_err), 0);
    chk("rst_perf_stall", 32'(hz.perf_stall_cnt), 0);
    chk("rst_perf_flush", 32'(hz.perf_flush_cnt), 0);
    chk("rst_flush_id",  32'(hz.flush_id), 1);
    chk("rst_bubble_ex", 32'(hz.bubble_ex), 1);
    chk("rst_stall_if",  32'(hz.stall_if), 0);
    chk("rst_freeze",    32'(hz.freeze), 0);
    chk("rst_fwd",       32'({hz.forward_a, hz.forward_b}), 0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_reset = 1'b1;
  endtask

  initial begin
    idle();
    i_reset = 1'b0;
    #3;
    do_reset();

    // forwarding priority: EX wins over MEM and WB; x0 never forwards
    idle();
    hz.rd_ex = 5; hz.rd_wren_ex = 1;
    hz.rd_mem = 5; hz.rd_wren_mem = 1;
    hz.rd_wb = 5; hz.rd_wren_wb = 1;
    hz.instr_id = mk_instr(5, 0);
    step();
    chk("t1_fwd_a", 32'(hz.forward_a), 3);
    chk("t1_fwd_b", 32'(hz.forward_b), 0);
    chk("t1_stall", 32'(hz.stall_if), 0);

    // load directly ahead of its consumer: 2 stall cycles, then WB forward
    do_reset();
    idle();
    hz.instr_id = mk_instr(1, 7);
    hz.rd_ex = 7; hz.rd_wren_ex = 1; hz.is_load_ex = 1;
    step();
    hz.rd_ex = 0; hz.rd_wren_ex = 0; hz.is_load_ex = 0;
    hz.rd_mem = 7; hz.rd_wren_mem = 1; hz.is_load_mem = 1;
    step();
    hz.rd_mem = 0; hz.rd_wren_mem = 0; hz.is_load_mem = 0;
    hz.rd_wb = 7; hz.rd_wren_wb = 1;
    step();
    chk("t2_fwd_b", 32'(hz.forward_b), 1);
    chk("t2_stall_cnt", 32'(hz.perf_stall_cnt), 2);

    // memory wait of 3 cycles, then release
    do_reset();
    idle();
    hz.mem_req = 1;
    repeat (3) step();
    chk("t3_state_wait", 32'(hz.state), 1);
    hz.mem_ready = 1;
    step();
    chk("t3_state_run", 32'(hz.state), 0);

    // branch taken during the wait flushes only on the release cycle
    do_reset();
    idle();
    hz.mem_req = 1;
    step();
    hz.br_taken_ex = 1;
    step();
    hz.br_taken_ex = 0;
    repeat (2) step();
    hz.mem_ready = 1;
    step();
    chk("t4_flush_cnt", 32'(hz.perf_flush_cnt), 1);
    hz.mem_req = 0; hz.mem_ready = 0;
    step();

    // timeout into ERROR, then async reset out of it
    do_reset();
    idle();
    hz.mem_req = 1;
    repeat (TIMEOUT + 1) step();
    chk("t5_state_err", 32'(hz.state), 2);
    chk("t5_mem_err", 32'(hz.mem_err), 1);
    hz.mem_ready = 1;
    repeat (2) step();
    #2;
    do_reset();

    // long freeze saturates the stall counter
    idle();
    hz.mem_req = 1;
    repeat (CNT_MAX + 6) step();
    chk("t6_stall_sat", 32'(hz.perf_stall_cnt), 32'(CNT_MAX));
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      hz.instr_id    = mk_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      hz.rd_ex       = 5'($urandom_range(0, 7));
      hz.rd_wren_ex  = 1'($urandom_range(0, 1));
      hz.is_load_ex  = ($urandom_range(0, 3) == 0);
      hz.rd_mem      = 5'($urandom_range(0, 7));
      hz.rd_wren_mem = 1'($urandom_range(0, 1));
      hz.is_load_mem = ($urandom_range(0, 3) == 0);
      hz.rd_wb       = 5'($urandom_range(0, 7));
      hz.rd_wren_wb  = 1'($urandom_range(0, 1));
      hz.br_taken_ex = ($urandom_range(0, 4) == 0);
      hz.mem_req     = ($urandom_range(0, 2) == 0);
      hz.mem_ready   = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 39) == 0)
        do_reset();
      else
        step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
